cache_mem_responder: RTL and testbench
======================================

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, the address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the beat data width.
REQ-003 SHALL have parameter LINE_WORDS, default 16, the beats per burst (power of two).
REQ-004 SHALL have parameter MEM_AW, default 10, the log2 of backing-store depth in words.
REQ-005 SHALL have parameter READ_LATENCY, default 2, the cycles from request accept to first read beat (at least 1).
REQ-006 SHALL have port clk, input, 1 bit; rising-edge clock.
REQ-007 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-008 SHALL have port mem_ce, input, 1 bit; request / write-beat strobe.
REQ-009 SHALL have port mem_we, input, 1 bit; 0 = line read, 1 = line write.
REQ-010 SHALL have port mem_addr, input, BUS_WIDTH bits; byte address.
REQ-011 SHALL have port mem_wdata, input, DATA_WIDTH bits; write beat data.
REQ-012 SHALL have port mem_wmask, input, DATA_WIDTH/8 bits; byte enables.
REQ-013 SHALL have port mem_rdata, output, DATA_WIDTH bits; read beat data.
REQ-014 SHALL have port mem_rdata_valid, output, 1 bit; read beat valid.
REQ-015 SHALL have port mem_write_respone, output, 1 bit; write beat acknowledged.
REQ-016 SHALL have port busy, output, 1 bit; high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, RD_WAIT, RD_BURST and WR_BURST.
REQ-018 SHALL accept a request only in IDLE with mem_ce=1, capturing line base = word address mem_addr[MEM_AW+1:2] with its low log2(LINE_WORDS) bits cleared.
REQ-019 SHALL ignore address bits above MEM_AW+1, so addressing wraps modulo the store depth.
REQ-020 Read accept SHALL enter RD_WAIT and count READ_LATENCY cycles; the first mem_rdata_valid SHALL occur in cycle READ_LATENCY+1 after the accept cycle.
REQ-021 RD_BURST SHALL emit beats 0..LINE_WORDS-1 in ascending order, with mem_rdata = mem[base+beat]; the beat index SHALL wrap within the line.
REQ-022 After the last read beat, the block SHALL return to IDLE, and mem_rdata_valid SHALL be 0 in the following cycle.
REQ-023 Write accept SHALL write beat 0 (mem_wdata, masked by mem_wmask) in the accept cycle, then enter WR_BURST.
REQ-024 WR_BURST SHALL write beats 1..LINE_WORDS-1, one per cycle in which mem_ce=1 and mem_we=1; cycles with mem_ce=0 SHALL stall without advancing the beat.
REQ-025 mem_write_respone SHALL pulse for one cycle, registered, in the cycle after each written beat.
REQ-026 After the last write beat, the block SHALL return to IDLE; the final response pulse coincides with the first IDLE cycle, and a new request SHALL be acceptable in that cycle.
REQ-027 mem_ce SHALL be ignored in RD_WAIT and RD_BURST, and mem_we=0 SHALL be ignored in WR_BURST.
REQ-028 A byte with mem_wmask=0 SHALL leave the stored byte unchanged.
REQ-029 mem_rdata SHALL be 0 whenever mem_rdata_valid=0.

Reset
REQ-030 Reset SHALL force state IDLE, clear the beat and latency counters, and drive mem_rdata_valid=0, mem_write_respone=0, mem_rdata=0 and busy=0 in the next cycle.
REQ-031 Reset asserted mid-burst SHALL abort the burst; beats already written SHALL persist.
REQ-032 Store contents SHALL NOT be cleared by reset.

Configuration
REQ-033 Macro MEM_RESP_STALL_EN defined SHALL add an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) stepping every cycle; in RD_BURST, lfsr[0]=1 SHALL withhold the beat (valid=0, beat held).
REQ-034 Without MEM_RESP_STALL_EN, read beats SHALL be issued on LINE_WORDS consecutive cycles; write behaviour SHALL be identical either way.

Structure
REQ-035 A shared package SHALL hold the state encoding (IDLE=2'b00, RD_WAIT=2'b01, RD_BURST=2'b10, WR_BURST=2'b11) and the LFSR seed/taps constants.
REQ-036 The backing store SHALL be one sub-module, resp_mem_array: a synchronous-write array with per-byte enables and combinational read.

Verification
REQ-037 Preload mem[0x40..0x4F]=0x1000+i; read at mem_addr=0x104 -> 16 valid beats 0x1000..0x100F starting cycle 3 after accept, contiguous (macro off).
REQ-038 Write burst at 0x200 with data 0xA0+i and mask 4'hF, one beat per cycle -> 16 response pulses, each one cycle after its beat; a subsequent read returns 0xA0..0xAF.
REQ-039 Write beat 3 with mask 4'b0101 and data 0xDEADBEEF over 0x11223344 -> mem reads 0x11AD33EF.
REQ-040 Write burst with mem_ce low for 2 cycles after beat 5 -> no response during the gap, beat 6 written to base+6, total of 16 responses.
REQ-041 Reset at read beat 7 -> valid=0 and busy=0 the next cycle; a new read request is accepted immediately.
REQ-042 With MEM_RESP_STALL_EN defined, a read -> exactly 16 valid beats in order with gaps matching lfsr[0] from seed 8'hA5; mem_addr=0xFFFF_F000 aliases to word 0x000 when MEM_AW=10.

Source files
------------

// File: rtl/cache_mem_responder_pkg.sv
// Shared constants for the cache memory responder: FSM state encoding and
// the stall LFSR seed/taps plus its next-state helper.
package cache_mem_responder_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE     = 2'b00;
    localparam logic [1:0] ST_RD_WAIT  = 2'b01;
    localparam logic [1:0] ST_RD_BURST = 2'b10;
    localparam logic [1:0] ST_WR_BURST = 2'b11;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left; the taps are
    // state bits 7,5,4,3 and the feedback bit enters at bit 0.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/cache_mem_responder_mem_array.sv
// resp_mem_array: backing store for the responder. Synchronous write with
// per-byte enables, combinational read. Contents are never reset.
module resp_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [MEM_AW-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic [MEM_AW-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    // Byte-masked write; unmasked bytes keep their old value.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_mask[b]) begin
                    mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: line-burst memory responder behind a cache.
// A request is a single mem_ce strobe in IDLE. Reads answer after
// READ_LATENCY wait cycles with LINE_WORDS beats; writes take beat 0 with
// the request and the remaining beats one per mem_ce cycle.
// Optional feature: define MEM_RESP_STALL_EN to add LFSR-driven read stalls.
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int BUS_WIDTH    = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LINE_WORDS   = 16,
    parameter int MEM_AW       = 10,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_ce,
    input  logic                    mem_we,
    input  logic [BUS_WIDTH-1:0]    mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH/8-1:0] mem_wmask,
    output logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    mem_rdata_valid,
    output logic                    mem_write_respone,
    output logic                    busy,
    output logic [1:0]              dbg_state
);
    // Handshake: there is no ready. mem_ce is sampled only in IDLE (request)
    // and in WR_BURST (write beat, qualified by mem_we); the requester must
    // watch busy. mem_rdata_valid marks each read beat and is never
    // back-pressured. mem_write_respone is a registered one-cycle ack that
    // follows every written beat by exactly one cycle.

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int LAT_W = $clog2(READ_LATENCY + 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    logic [1:0]            state;
    logic [OFF_W-1:0]      beat;
    logic [LAT_W-1:0]      lat_cnt;
    logic [MEM_AW-1:0]     base_q;
    logic                  wr_resp_q;
    logic                  stall;
    logic                  wr_fire;
    logic                  rd_fire;
    logic [MEM_AW-1:0]     req_base;
    logic [MEM_AW-1:0]     line_addr;
    logic [MEM_AW-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_addr_bits;

    // High address bits wrap (store depth) and byte-offset bits are ignored.
    assign unused_addr_bits = ^{mem_addr[BUS_WIDTH-1:MEM_AW+2], mem_addr[1:0]};

    assign req_base  = mem_addr[MEM_AW+1:2] & ~MEM_AW'(LINE_WORDS - 1);
    assign line_addr = base_q + MEM_AW'(beat);

`ifdef MEM_RESP_STALL_EN
    logic [7:0] lfsr;

    // Free-running stall LFSR; bit 0 withholds the current read beat.
    always_ff @(posedge clk) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next(lfsr);
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign wr_fire = !reset && mem_ce && mem_we &&
                     ((state == ST_IDLE) || (state == ST_WR_BURST));
    assign wr_addr = (state == ST_IDLE) ? req_base : line_addr;
    assign rd_fire = (state == ST_RD_BURST) && !stall;

    resp_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_AW     (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_fire),
        .wr_addr (wr_addr),
        .wr_data (mem_wdata),
        .wr_mask (mem_wmask),
        .rd_addr (line_addr),
        .rd_data (rd_data)
    );

    assign mem_rdata_valid   = rd_fire;
    assign mem_rdata         = rd_fire ? rd_data : '0;
    assign mem_write_respone = wr_resp_q;
    assign busy              = (state != ST_IDLE);
    assign dbg_state         = state;

    // Burst FSM: request capture, read latency count, beat sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            beat      <= '0;
            lat_cnt   <= '0;
            base_q    <= '0;
            wr_resp_q <= 1'b0;
        end else begin
            wr_resp_q <= wr_fire;
            case (state)
                ST_IDLE: begin
                    if (mem_ce) begin
                        base_q  <= req_base;
                        lat_cnt <= '0;
                        if (mem_we) begin
                            beat  <= OFF_W'(1);
                            state <= ST_WR_BURST;
                        end else begin
                            beat  <= '0;
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (lat_cnt == LAT_W'(READ_LATENCY - 1)) state <= ST_RD_BURST;
                    else                                      lat_cnt <= lat_cnt + 1'b1;
                end
                ST_RD_BURST: begin
                    if (!stall) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) state <= ST_IDLE;
                    end
                end
                ST_WR_BURST: begin
                    if (mem_ce && mem_we) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder (default parameters). The model is a word
// array plus a per-cycle timeline of expected outputs filled in by the
// driver tasks; one compare process checks the DUT against it every cycle.
module tb_cache_mem_responder;
    localparam int N = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wmask = '0;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        mem_write_respone;
    logic        busy;
    logic [1:0]  dbg_state;

    cache_mem_responder dut (
        .clk               (clk),
        .reset             (reset),
        .mem_ce            (mem_ce),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wmask         (mem_wmask),
        .mem_rdata         (mem_rdata),
        .mem_rdata_valid   (mem_rdata_valid),
        .mem_write_respone (mem_write_respone),
        .busy              (busy),
        .dbg_state         (dbg_state)
    );

    // clock / cycle counter: cycle n starts at the n-th rising edge
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // model state and expected timeline
    logic [31:0] model_mem [0:1023];
    bit          exp_v [N];
    bit [31:0]   exp_d [N];
    bit          exp_r [N];
    bit          exp_b [N];
    bit          lit_v [N];
    bit [31:0]   lit_d [N];
    logic [31:0] wd [16];
    logic [3:0]  wm [16];
    int          seed_cycle = 0;
    bit          cmp_on = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        if (cmp_on && cyc < N) begin
            chk("rdata_valid", {31'b0, mem_rdata_valid}, {31'b0, exp_v[cyc]});
            chk("rdata", mem_rdata, exp_v[cyc] ? exp_d[cyc] : 32'h0);
            chk("write_resp", {31'b0, mem_write_respone}, {31'b0, exp_r[cyc]});
            chk("busy", {31'b0, busy}, {31'b0, exp_b[cyc]});
            if (lit_v[cyc]) begin
                chk("literal_valid", {31'b0, mem_rdata_valid}, 32'h1);
                chk("literal_data", mem_rdata, lit_d[cyc]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    function automatic int line_base(input logic [31:0] a);
        return ((a >> 2) & 1023) & ~15;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = m[k] ? nw[k*8 +: 8] : old[k*8 +: 8];
        return r;
    endfunction

    // Is the read beat withheld in cycle n?
    function automatic bit stall_at(input int n);
`ifdef MEM_RESP_STALL_EN
        logic [7:0] s = 8'hA5;
        for (int i = seed_cycle; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return s[0];
`else
        return (n < 0);
`endif
    endfunction

    // driver tasks: every drive happens 1 ns after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    // Write one line from wd/wm; optional stall gap after beat gap_after.
    // gap_ce=1 drives mem_ce=1 with mem_we=0 during the gap.
    task automatic write_line(input logic [31:0] addr, input int gap_after,
                              input int gap_len, input bit gap_ce);
        int base = line_base(addr);
        for (int b = 0; b < 16; b++) begin
            if (gap_after >= 0 && b == gap_after + 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    mem_ce = gap_ce; mem_we = 1'b0; mem_wdata = 32'hFFFF_FFFF; mem_wmask = 4'hF;
                    exp_b[cyc+1] = 1'b1;
                    step();
                end
            end
            mem_ce = 1'b1; mem_we = 1'b1;
            mem_addr = (b == 0) ? addr : 32'hFFFF_FFFC;
            mem_wdata = wd[b]; mem_wmask = wm[b];
            model_mem[base+b] = merge(model_mem[base+b], wd[b], wm[b]);
            exp_r[cyc+1] = 1'b1;
            if (b < 15) exp_b[cyc+1] = 1'b1;
            step();
        end
        mem_ce = 1'b0; mem_we = 1'b0;
    endtask

    // Read one line. noisy keeps mem_ce/mem_we high during the burst;
    // abort_beat>=0 pulses reset in that beat's cycle; lit_beat>=0 pins a
    // hand-computed value for that beat.
    task automatic read_line(input logic [31:0] addr, input bit noisy, input int abort_beat,
                             input int lit_beat, input logic [31:0] lit_val);
        int c = cyc;
        int base = line_base(addr);
        int n = c + 3;
        int last;
        int beat_cyc [16];
        mem_ce = 1'b1; mem_we = 1'b0; mem_addr = addr;
        for (int b = 0; b < 16; ) begin
            if (!stall_at(n)) begin
                exp_v[n] = 1'b1; exp_d[n] = model_mem[base+b]; beat_cyc[b] = n; b++;
            end
            n++;
        end
        last = n - 1;
        for (int k = c + 1; k <= last; k++) exp_b[k] = 1'b1;
        if (lit_beat >= 0) begin
`ifdef MEM_RESP_STALL_EN
            lit_v[beat_cyc[lit_beat]] = 1'b1; lit_d[beat_cyc[lit_beat]] = lit_val;
`else
            lit_v[c + 3 + lit_beat] = 1'b1; lit_d[c + 3 + lit_beat] = lit_val;
`endif
        end
        step();
        if (noisy) begin
            mem_ce = 1'b1; mem_we = 1'b1; mem_wdata = 32'hBAD0_BAD0; mem_wmask = 4'hF; mem_addr = '0;
        end else begin
            mem_ce = 1'b0;
        end
        if (abort_beat >= 0) begin
            int r = beat_cyc[abort_beat];
            wait_to(r);
            reset = 1'b1; mem_ce = 1'b0; mem_we = 1'b0;
            for (int k = r + 1; k <= last; k++) begin
                exp_v[k] = 1'b0; exp_b[k] = 1'b0; lit_v[k] = 1'b0;
            end
            seed_cycle = r + 1;
            step();
            reset = 1'b0;
        end else begin
            wait_to(last);
            mem_ce = 1'b0; mem_we = 1'b0;
            step();
        end
    endtask

    task automatic fill(input logic [31:0] start, input logic [3:0] m);
        for (int i = 0; i < 16; i++) begin
            wd[i] = start + 32'(i); wm[i] = m;
        end
    endtask

    initial begin
        // reset held through cycles 0..2
        seed_cycle = 3;
        wait_to(3);
        reset = 1'b0;
        cmp_on = 1'b1;
        #2 chk("reset_state", {30'b0, dbg_state}, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);

        // preload word 0x40.. via a write, then back-to-back read at 0x104
        fill(32'h1000, 4'hF);
        write_line(32'h0000_0100, -1, 0, 1'b0);
        read_line(32'h0000_0104, 1'b1, -1, 0, 32'h0000_1000);
        read_line(32'h0000_0104, 1'b0, -1, 15, 32'h0000_100F);

        // full write burst at 0x200
        fill(32'hA0, 4'hF);
        write_line(32'h0000_0200, -1, 0, 1'b0);
        read_line(32'h0000_0200, 1'b0, -1, 0, 32'h0000_00A0);
        read_line(32'h0000_023C, 1'b0, -1, 15, 32'h0000_00AF);

        // masked write over existing data
        fill(32'h300, 4'hF);
        wd[3] = 32'h1122_3344;
        write_line(32'h0000_0300, -1, 0, 1'b0);
        fill(32'h5500, 4'hF);
        wd[3] = 32'hDEAD_BEEF; wm[3] = 4'b0101;
        write_line(32'h0000_0300, -1, 0, 1'b0);
        read_line(32'h0000_0300, 1'b0, -1, 3, 32'h11AD_33EF);

        // write stalls: mem_ce low for 2 cycles, then mem_we low with mem_ce high
        fill(32'h4000, 4'hF);
        write_line(32'h0000_0400, 5, 2, 1'b0);
        read_line(32'h0000_0400, 1'b0, -1, 6, 32'h0000_4006);
        fill(32'h6000, 4'b0011);
        write_line(32'h0000_0400, 9, 1, 1'b1);
        read_line(32'h0000_0400, 1'b0, -1, 10, 32'h0000_600A);

        // reset at read beat 7, then an immediate new read
        read_line(32'h0000_0104, 1'b0, 7, -1, 32'h0);
        read_line(32'h0000_0200, 1'b0, -1, 1, 32'h0000_00A1);

        // address aliasing: 0xFFFF_F000 maps to word 0
        fill(32'h7000, 4'hF);
        write_line(32'h0000_0000, -1, 0, 1'b0);
        read_line(32'hFFFF_F000, 1'b0, -1, 4, 32'h0000_7004);

        step(); step();
        chk("end_state", {30'b0, dbg_state}, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
